// File: rtl/max_pooling_stream.sv
// max_pooling_stream: streaming 2-D pooling over non-overlapping POOL x POOL windows.
//
// Pixels arrive one per handshake in raster order (row-major, IMG_W x IMG_H). A horizontal
// partial is combined across each window row, and the per-window-column line buffer carries
// partials down the window rows. The window result goes into a 1-entry output register with
// ready/valid backpressure. Trailing columns and rows that do not fill a whole window are
// accepted and discarded.
//
// Optional feature: define POOL_AVG_MODE_EN to add input i_avg_mode. It selects average pooling
// per window (floor of the signed sum >>> 2*log2(POOL)). Without the macro the block does max
// pooling only.
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-low reset
//   pixel_in        signed input pixel, DATA_W bits
//   i_data_valid    pixel_in valid
//   i_sof           pixel_in is pixel (0,0) of a new frame
//   o_in_ready      block can accept pixel_in this cycle
//   o_pooled_pixel  pooled result, DATA_W bits
//   o_data_valid    o_pooled_pixel valid
//   i_out_ready     downstream accepts o_pooled_pixel
//   i_avg_mode      (POOL_AVG_MODE_EN only) 1 = average, 0 = max; sampled on window's first pixel
//   o_frame_done    one-cycle pulse alongside the result of the frame's last window
module max_pooling_stream #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned POOL   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              i_data_valid,
  input  logic              i_sof,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_pooled_pixel,
  output logic              o_data_valid,
  input  logic              i_out_ready,
`ifdef POOL_AVG_MODE_EN
  input  logic              i_avg_mode,
`endif
  output logic              o_frame_done
);

  localparam int unsigned Log2Pool = $clog2(POOL);
  localparam int unsigned WinCols  = IMG_W / POOL;
  localparam int unsigned WinRows  = IMG_H / POOL;
  localparam int unsigned CropW    = WinCols * POOL;
  localparam int unsigned CropH    = WinRows * POOL;
  localparam int unsigned ColW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned WcolW    = (WinCols > 1) ? $clog2(WinCols) : 1;
  localparam int unsigned AvgShift = 2 * Log2Pool;
`ifdef POOL_AVG_MODE_EN
  // Room for the full window sum so the average never overflows.
  localparam int unsigned AccW = DATA_W + AvgShift;
`else
  localparam int unsigned AccW = DATA_W;
`endif

  logic [ColW-1:0] col_q, col_d, cur_col;
  logic [RowW-1:0] row_q, row_d, cur_row;
  logic [Log2Pool-1:0] px, py;
  logic [WcolW-1:0] wcol;
  logic accept, in_crop, last_px, last_wcol, last_wrow, cur_avg, load;
  logic lb_we;

  logic signed [AccW-1:0] pix_ext, h_val, lb_rd, v_val, lb_wdata, res_full;
  logic signed [AccW-1:0] partial_q, partial_d;
  logic signed [AccW-1:0] linebuf_q [WinCols];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              frame_done_q, frame_done_d;

  function automatic logic signed [AccW-1:0] combine(input logic signed [AccW-1:0] a,
                                                     input logic signed [AccW-1:0] b,
                                                     input logic avg);
    if (avg) begin
      return a + b;
    end
    return (a > b) ? a : b;
  endfunction

  assign o_in_ready     = !out_valid_q | i_out_ready;
  assign accept         = i_data_valid & o_in_ready;
  assign o_data_valid   = out_valid_q;
  assign o_pooled_pixel = out_data_q;
  assign o_frame_done   = frame_done_q;

  // A start-of-frame pixel is treated as (0,0) regardless of where the counters stand.
  assign cur_col   = i_sof ? '0 : col_q;
  assign cur_row   = i_sof ? '0 : row_q;
  assign px        = cur_col[Log2Pool-1:0];
  assign py        = cur_row[Log2Pool-1:0];
  assign wcol      = WcolW'(cur_col >> Log2Pool);
  assign last_px   = (px == Log2Pool'(POOL - 1));
  assign last_wcol = (wcol == WcolW'(WinCols - 1));
  assign last_wrow = ((cur_row >> Log2Pool) == RowW'(WinRows - 1));
  // One extra bit so a crop equal to a power-of-two image size still compares correctly.
  assign in_crop   = ({1'b0, cur_col} < (ColW + 1)'(CropW)) &&
                     ({1'b0, cur_row} < (RowW + 1)'(CropH));

`ifdef POOL_AVG_MODE_EN
  // Mode is latched per window column on the window's first pixel and held for that window.
  logic avg_mode_q [WinCols];

  assign cur_avg = ((px == '0) && (py == '0)) ? i_avg_mode : avg_mode_q[wcol];

  always_ff @(posedge clk) begin
    if (accept && in_crop && (px == '0) && (py == '0)) begin
      avg_mode_q[wcol] <= i_avg_mode;
    end
  end
`else
  assign cur_avg = 1'b0;
`endif

  always_comb begin
    pix_ext  = AccW'($signed(pixel_in));
    h_val    = (px == '0) ? pix_ext : combine(partial_q, pix_ext, cur_avg);
    lb_rd    = linebuf_q[wcol];
    v_val    = combine(lb_rd, h_val, cur_avg);
    res_full = cur_avg ? (v_val >>> AvgShift) : v_val;

    partial_d = partial_q;
    lb_we     = 1'b0;
    lb_wdata  = h_val;
    load      = 1'b0;
    if (accept && in_crop) begin
      partial_d = h_val;
      if (last_px) begin
        if (py == '0) begin
          // First window row starts the column fresh; stale linebuf contents are ignored.
          lb_we    = 1'b1;
          lb_wdata = h_val;
        end else if (py != Log2Pool'(POOL - 1)) begin
          lb_we    = 1'b1;
          lb_wdata = v_val;
        end else begin
          load = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (i_out_ready) begin
      out_valid_d = 1'b0;
    end
    // A new result overrides the consume, so back-to-back results never drop.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = res_full[DATA_W-1:0];
    end
    frame_done_d = load && last_wcol && last_wrow;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == ColW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == RowW'(IMG_H - 1)) ? '0 : cur_row + RowW'(1);
      end else begin
        col_d = cur_col + ColW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      partial_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      partial_q    <= partial_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer is never reset: every column is written at py==0 before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[wcol] <= lb_wdata;
    end
  end

endmodule

// File: tb/tb_max_pooling_stream.sv
// Bench for max_pooling_stream: a 4x4 POOL=2 instance and a 5x5 POOL=2 instance (trailing
// row/column discard). Outputs are collected on the falling edge whenever a handshake is due.
module tb_max_pooling_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] pix4, out4, pix5, out5;
  logic        vld4, sof4, rdy4, ordy4, dv4, fd4;
  logic        vld5, sof5, rdy5, ordy5, dv5, fd5;
`ifdef POOL_AVG_MODE_EN
  logic        avg4;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] q4[$], fdq4[$], q5[$], fdq5[$];

  max_pooling_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .POOL(2)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .pixel_in      (pix4),
    .i_data_valid  (vld4),
    .i_sof         (sof4),
    .o_in_ready    (rdy4),
    .o_pooled_pixel(out4),
    .o_data_valid  (dv4),
    .i_out_ready   (ordy4),
`ifdef POOL_AVG_MODE_EN
    .i_avg_mode    (avg4),
`endif
    .o_frame_done  (fd4)
  );

  max_pooling_stream #(.DATA_W(16), .IMG_W(5), .IMG_H(5), .POOL(2)) dut5 (
    .clk           (clk),
    .reset         (reset),
    .pixel_in      (pix5),
    .i_data_valid  (vld5),
    .i_sof         (sof5),
    .o_in_ready    (rdy5),
    .o_pooled_pixel(out5),
    .o_data_valid  (dv5),
    .i_out_ready   (ordy5),
`ifdef POOL_AVG_MODE_EN
    .i_avg_mode    (1'b0),
`endif
    .o_frame_done  (fd5)
  );

  always @(negedge clk) begin
    if (dv4 && ordy4) q4.push_back(out4);
    if (fd4) fdq4.push_back(out4);
    if (dv5 && ordy5) q5.push_back(out5);
    if (fd5) fdq5.push_back(out5);
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic push4(input logic [15:0] p, input logic s);
    logic acc;
    acc  = 1'b0;
    pix4 = p;
    sof4 = s;
    vld4 = 1'b1;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = rdy4;
      @(posedge clk);
      #1;
    end
    vld4 = 1'b0;
    sof4 = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push4_timeout got=stalled want=accepted pixel=%0h", p);
    end
  endtask

  task automatic push5(input logic [15:0] p, input logic s);
    logic acc;
    acc  = 1'b0;
    pix5 = p;
    sof5 = s;
    vld5 = 1'b1;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = rdy5;
      @(posedge clk);
      #1;
    end
    vld5 = 1'b0;
    sof5 = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push5_timeout got=stalled want=accepted pixel=%0h", p);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dv4 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", dv4); end
    total++;
    if (out4 !== 16'h0) begin bad++; $display("FAIL rst_data got=%0h want=0", out4); end
    total++;
    if (fd4 !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b want=0", fd4); end
    total++;
    if (dv5 !== 1'b0) begin bad++; $display("FAIL rst_valid5 got=%b want=0", dv5); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (rdy4 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", rdy4); end
  endtask

  // No i_sof: relies on the counters starting at (0,0) after reset.
  task automatic test_basic_frame;
    logic [15:0] exp [4];
    logic [15:0] got;
    exp = '{16'd5, 16'd7, 16'd13, 16'd15};
    q4.delete();
    fdq4.delete();
    for (int i = 0; i < 16; i++) begin
      push4(16'(i), 1'b0);
      if (i == 4) begin
        total++;
        if (dv4 !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", dv4); end
      end
      if (i == 5) begin
        total++;
        if (dv4 !== 1'b1 || out4 !== 16'd5) begin
          bad++;
          $display("FAIL basic_latency got=%b/%0h want=1/5", dv4, out4);
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q4.size() != 4) begin bad++; $display("FAIL basic_count got=%0d want=4", q4.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q4.size()) ? q4[i] : 16'hxxxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL basic_out%0d got=%0h want=%0h", i, got, exp[i]);
      end
    end
    got = (fdq4.size() > 0) ? fdq4[0] : 16'hxxxx;
    total++;
    if (fdq4.size() != 1 || got !== 16'd15) begin
      bad++;
      $display("FAIL basic_frame_done got=%0d pulses/%0h want=1 pulse/f", fdq4.size(), got);
    end
  endtask

  // Shared by the negative-data test and the post-reset restart.
  task automatic send_neg_frame_and_check(input string tag);
    logic [15:0] frame [16];
    logic [15:0] exp [4];
    logic [15:0] got;
    frame = '{16'hFFFD, 16'hFFF8, 16'h8000, 16'h8000,
              16'hFFFF, 16'hFFEC, 16'h8000, 16'h8000,
              16'h0007, 16'h0007, 16'hFFFB, 16'h0064,
              16'h0007, 16'h0007, 16'h0064, 16'h8000};
    exp = '{16'hFFFF, 16'h8000, 16'h0007, 16'h0064};
    q4.delete();
    fdq4.delete();
    for (int i = 0; i < 16; i++) push4(frame[i], i == 0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q4.size() != 4) begin
      bad++;
      $display("FAIL %s_count got=%0d want=4", tag, q4.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < q4.size()) ? q4[i] : 16'hxxxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL %s_out%0d got=%0h want=%0h", tag, i, got, exp[i]);
      end
    end
    got = (fdq4.size() > 0) ? fdq4[0] : 16'hxxxx;
    total++;
    if (fdq4.size() != 1 || got !== 16'h0064) begin
      bad++;
      $display("FAIL %s_frame_done got=%0d pulses/%0h want=1 pulse/64", tag, fdq4.size(), got);
    end
  endtask

  task automatic test_negative;
    send_neg_frame_and_check("neg");
  endtask

  task automatic test_sof_resync;
    logic [15:0] exp [4];
    logic [15:0] got;
    exp = '{16'd5, 16'd7, 16'd13, 16'd15};
    for (int i = 0; i < 3; i++) push4(16'd900 + 16'(i), i == 0);
    q4.delete();
    fdq4.delete();
    for (int i = 0; i < 16; i++) push4(16'(i), i == 0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q4.size() != 4) begin bad++; $display("FAIL sof_count got=%0d want=4", q4.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q4.size()) ? q4[i] : 16'hxxxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL sof_out%0d got=%0h want=%0h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp [4];
    logic [15:0] got;
    exp = '{16'd25, 16'd27, 16'd33, 16'd35};
    q4.delete();
    fdq4.delete();
    ordy4 = 1'b0;
    for (int i = 0; i < 6; i++) push4(16'd20 + 16'(i), i == 0);
    // Pixel 6 must stall behind the unconsumed result.
    pix4 = 16'd26;
    vld4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rdy4 !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", rdy4); end
    total++;
    if (dv4 !== 1'b1 || out4 !== 16'd25) begin
      bad++;
      $display("FAIL bp_held got=%b/%0h want=1/19", dv4, out4);
    end
    ordy4 = 1'b1;
    push4(16'd26, 1'b0);
    ordy4 = 1'b0;
    push4(16'd27, 1'b0);
    total++;
    if (rdy4 !== 1'b0 || out4 !== 16'd27) begin
      bad++;
      $display("FAIL bp_second got=%b/%0h want=0/1b", rdy4, out4);
    end
    ordy4 = 1'b1;
    for (int i = 8; i < 16; i++) push4(16'd20 + 16'(i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q4.size() != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", q4.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q4.size()) ? q4[i] : 16'hxxxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL bp_out%0d got=%0h want=%0h", i, got, exp[i]);
      end
    end
    got = (fdq4.size() > 0) ? fdq4[0] : 16'hxxxx;
    total++;
    if (fdq4.size() != 1 || got !== 16'd35) begin
      bad++;
      $display("FAIL bp_frame_done got=%0d pulses/%0h want=1 pulse/23", fdq4.size(), got);
    end
  endtask

  // Two frames back to back, second without i_sof; column 4 and row 4 carry large decoys.
  task automatic test_trailing;
    logic [15:0] exp [4];
    logic [15:0] got;
    logic [15:0] p;
    exp = '{16'd6, 16'd8, 16'd16, 16'd18};
    q5.delete();
    fdq5.delete();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          p = 16'(r * 5 + c);
          if (r == 4 || c == 4) p = p + 16'd1000;
          push5(p, (f == 0) && (r == 0) && (c == 0));
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q5.size() != 8) begin bad++; $display("FAIL trail_count got=%0d want=8", q5.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < q5.size()) ? q5[i] : 16'hxxxx;
      total++;
      if (got !== exp[i % 4]) begin
        bad++;
        $display("FAIL trail_out%0d got=%0h want=%0h", i, got, exp[i % 4]);
      end
    end
    total++;
    if (fdq5.size() != 2) begin
      bad++;
      $display("FAIL trail_frame_done got=%0d pulses want=2", fdq5.size());
    end
  endtask

  task automatic test_mid_reset;
    ordy4 = 1'b0;
    for (int i = 0; i < 6; i++) push4(16'd500 + 16'(i), i == 0);
    // Row 1, column 2 is pending and a result is held when reset hits.
    pix4 = 16'd506;
    vld4 = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (dv4 !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b want=0", dv4); end
    total++;
    if (out4 !== 16'h0) begin bad++; $display("FAIL mrst_data got=%0h want=0", out4); end
    total++;
    if (rdy4 !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got=%b want=1", rdy4); end
    vld4  = 1'b0;
    ordy4 = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_neg_frame_and_check("mrst");
  endtask

`ifdef POOL_AVG_MODE_EN
  task automatic test_avg;
    logic [15:0] frame [16];
    logic        wmode [4];
    logic [15:0] exp [4];
    logic [15:0] got;
    int          w;
    frame = '{16'h0001, 16'h0002, 16'hFFFF, 16'hFFFE,
              16'h0003, 16'h0005, 16'hFFFD, 16'hFFFB,
              16'h0001, 16'h0009, 16'h0004, 16'h0004,
              16'h0004, 16'h0002, 16'h0004, 16'h0004};
    wmode = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp   = '{16'h0002, 16'hFFFD, 16'h0009, 16'h0004};
    q4.delete();
    for (int i = 0; i < 16; i++) begin
      w = ((i / 8) * 2) + ((i % 4) / 2);
      // Opposite mode on non-first pixels: the window must hold its sampled mode.
      avg4 = ((i % 2) == 0 && ((i / 4) % 2) == 0) ? wmode[w] : !wmode[w];
      push4(frame[i], i == 0);
    end
    avg4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q4.size() != 4) begin bad++; $display("FAIL avg_count got=%0d want=4", q4.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q4.size()) ? q4[i] : 16'hxxxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL avg_out%0d got=%0h want=%0h", i, got, exp[i]);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    pix4  = '0;
    vld4  = 1'b0;
    sof4  = 1'b0;
    ordy4 = 1'b1;
    pix5  = '0;
    vld5  = 1'b0;
    sof5  = 1'b0;
    ordy5 = 1'b1;
`ifdef POOL_AVG_MODE_EN
    avg4  = 1'b0;
`endif
    test_reset();
    test_basic_frame();
    test_negative();
    test_sof_resync();
    test_backpressure();
    test_trailing();
    test_mid_reset();
`ifdef POOL_AVG_MODE_EN
    test_avg();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
